return_address_stack: RTL
=========================

// Module: return_address_stack
// PURPOSE
//  Hardware call/return stack in the EX stage. On a CALL it pushes the return
//  address (pc_1). On a RET it pops. It drives the STACK operand of the
//  next-address selector: top_addr is the address taken when pc_select = STACK.
//  Circular LIFO with occupancy count, full/empty status and sticky error flags.
// PARAMETERS
//  WIDTH   32  address width in bits
//  ADDR_W  3   log2 of depth; DEPTH = 2**ADDR_W = 8 entries
// PORTS
//  clk         in   1          rising-edge clock
//  reset       in   1          asynchronous, active-high reset
//  stall       in   1          1 = hold all state; push/pop ignored
//  push        in   1          CALL retiring: store push_addr
//  pop         in   1          RET retiring: discard top entry
//  push_addr   in   WIDTH      return address to store (pc_1 of the CALL)
//  clear_err   in   1          synchronous clear of overflow/underflow
//  top_addr    out  WIDTH      current top entry; 0 when empty
//  count       out  ADDR_W+1   occupancy, 0..DEPTH
//  empty       out  1          count == 0
//  full        out  1          count == DEPTH
//  overflow    out  1          sticky: push accepted while full
//  underflow   out  1          sticky: pop requested while empty
// BEHAVIOUR
//  - Storage: DEPTH x WIDTH regs. wr_ptr (ADDR_W bits) = next free slot.
//    top index = wr_ptr-1 mod DEPTH. All pointer arithmetic wraps mod DEPTH.
//  - Reset (async): wr_ptr=0, count=0, overflow=0, underflow=0 -> top_addr=0,
//    empty=1, full=0. Storage contents need not be cleared.
//  - All updates happen on the rising clk edge. top_addr/empty/full are
//    combinational from state, so an edge-N update is visible right after edge N.
//  - Operation per edge, with stall=0:
//    push only: mem[wr_ptr]<=push_addr; wr_ptr+1. count+1, saturating at DEPTH.
//      If already full, the oldest entry is overwritten (wrap) and overflow<=1.
//    pop only: if count>0: wr_ptr-1, count-1.
//      If empty: no state change, underflow<=1.
//    push & pop: top entry replaced: mem[wr_ptr-1]<=push_addr; ptr/count hold.
//      If empty, this is a plain push (count becomes 1); no underflow.
//    neither: hold.
//  - stall=1: push/pop/push_addr ignored, no flag updates. clear_err still acts.
//  - clear_err=1: overflow<=0, underflow<=0. A new error in the same cycle wins
//    and sets the flag.
//  - After DEPTH+k pushes (no pops), the k oldest entries are lost. Popping all
//    DEPTH valid entries then yields empty; the next pop is an underflow.
//  - top_addr = 0 whenever count==0, independent of stale storage.
//  - Reset asserted mid-operation aborts any push/pop in flight; state goes to
//    the reset values immediately, without waiting for a clock.
//  - No combinational path from push/pop to top_addr. This keeps the
//    next-address selector off the control critical path.
// TESTING
//  1 Reset then idle -> top_addr=0, count=0, empty=1, full=0, both flags 0.
//  2 Push 0x10,0x20,0x30 -> top=0x30, count=3. Pop -> top=0x20. Pop -> top=0x10.
//    Pop -> top=0, empty=1.
//  3 Push 0x100..0x900 (9 pushes, step 0x100) -> full=1, count=8, overflow=1,
//    top=0x900. 8 pops return 0x900..0x200. 9th pop -> underflow=1, count=0.
//  4 Push 0xA, then push=pop=1 with 0xB -> count=1, top=0xB. On empty, push=pop=1
//    with 0xC -> count=1, top=0xC, underflow=0.
//  5 stall=1 with push=1 for 3 cycles -> count/top unchanged. clear_err=1 with
//    overflow set -> overflow=0 next edge. clear_err and an empty pop in the
//    same cycle -> underflow=1.
//  6 Assert reset asynchronously between edges at count=5 -> count=0, top_addr=0
//    before the next edge. Pushing after release behaves as in test 2.

Source files
------------

// File: rtl/return_address_stack_if.sv
// Bundle of the return address stack's control and status signals.
// push and pop are single-cycle strobes with no ready back-pressure: a strobe
// is taken on the rising clock edge where it is high and stall is low.
// Status outputs reflect state after the most recent edge.
interface return_address_stack_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 3
);
    logic              stall;
    logic              push;
    logic              pop;
    logic [WIDTH-1:0]  push_addr;
    logic              clear_err;
    logic [WIDTH-1:0]  top_addr;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    // Pipeline side: issues CALL/RET strobes, reads the stack top.
    modport master (
        output stall, push, pop, push_addr, clear_err,
        input  top_addr, count, empty, full, overflow, underflow
    );

    // Stack side.
    modport slave (
        input  stall, push, pop, push_addr, clear_err,
        output top_addr, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/return_address_stack.sv
// Circular LIFO of return addresses for CALL/RET prediction in EX.
// When full, a push overwrites the oldest entry. top_addr depends only on
// registered state so the next-address selector never waits on push/pop.
module return_address_stack #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 3
) (
    input logic                   clk,
    input logic                   reset,
    return_address_stack_if.slave bus
);
    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] top_ptr;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;
    logic              underflow_q;

    logic              is_empty;
    logic              is_full;
    logic              push_only;
    logic              pop_only;
    logic              push_pop;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic              grow;
    logic              shrink;
    logic              set_ovf;
    logic              set_unf;

    // Decode the strobes into the operation for this edge.
    always_comb begin
        is_empty  = (count_q == '0);
        is_full   = (count_q == DEPTH_CNT);
        top_ptr   = wr_ptr - 1'b1;
        push_only = !bus.stall && bus.push && !bus.pop;
        pop_only  = !bus.stall && bus.pop && !bus.push;
        push_pop  = !bus.stall && bus.push && bus.pop;
        wr_en     = push_only || push_pop;
        // push+pop replaces the top in place, unless empty where it is a plain push
        wr_idx    = (push_pop && !is_empty) ? top_ptr : wr_ptr;
        grow      = push_only || (push_pop && is_empty);
        shrink    = pop_only && !is_empty;
        set_ovf   = push_only && is_full;
        set_unf   = pop_only && is_empty;
    end

    // Pointer, occupancy and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (grow) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (!is_full) begin
                    count_q <= count_q + 1'b1;
                end
            end else if (shrink) begin
                wr_ptr  <= wr_ptr - 1'b1;
                count_q <= count_q - 1'b1;
            end
            // a fresh error in the same cycle as clear_err keeps the flag set
            overflow_q  <= set_ovf || (overflow_q && !bus.clear_err);
            underflow_q <= set_unf || (underflow_q && !bus.clear_err);
        end
    end

    // Storage array; contents are meaningless outside the valid window.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= bus.push_addr;
        end
    end

    // Status outputs, all from registered state.
    always_comb begin
        bus.top_addr  = is_empty ? '0 : mem[top_ptr];
        bus.count     = count_q;
        bus.empty     = is_empty;
        bus.full      = is_full;
        bus.overflow  = overflow_q;
        bus.underflow = underflow_q;
    end
endmodule
